// File: rtl/voice_frame_scheduler.sv
// Voice frame scheduler: polls each enabled voice once per codec frame and mixes the samples into one output (VOICE_SCHED_SATURATE_EN: clamp instead of wrap).
// Latency: sample_valid comes 2 + sum(2 + answer cycles) cycles after new_frame; disabled voices cost 2 cycles each, so all-off gives 2*NUM_VOICES+2.
// Backpressure: none; new_frame while busy is dropped and flagged in sticky overrun, and a silent voice is abandoned after TIMEOUT cycles.
`timescale 1ns/1ps
module voice_frame_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  new_frame,
    input  logic [NUM_VOICES-1:0] voice_en,
    output logic [2:0]            voice_sel,
    output logic                  voice_start,
    input  logic                  voice_done,
    input  logic [15:0]           voice_sample,
    output logic [15:0]           sample_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err,
    input  logic                  clear_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [2:0]    INDEX_LAST = 3'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        OUTPUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         index;
    logic [CW-1:0]      wait_cnt;
    logic signed [18:0] acc;
    logic [15:0]        result;
    logic [7:0]         en_ext;
    logic               timeout_hit;

    // Widen the enable vector so a 3-bit index can select any legal voice count.
    assign en_ext      = 8'(voice_en);
    assign timeout_hit = (state == WAIT) && !voice_done && (wait_cnt == CNT_LAST);
    assign busy        = (state != IDLE);
    assign voice_sel   = index;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        voice_start = 1'b0;
        case (state)
            IDLE: begin
                if (new_frame) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (en_ext[index]) begin
                    voice_start = 1'b1;
                    state_nxt   = WAIT;
                end else begin
                    state_nxt = NEXT;
                end
            end
            WAIT: begin
                if (voice_done || timeout_hit) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                state_nxt = (index == INDEX_LAST) ? OUTPUT : ISSUE;
            end
            OUTPUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Voice index, answer timer and mix accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index    <= '0;
            wait_cnt <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_frame) begin
                        index <= '0;
                        acc   <= '0;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (voice_done) begin
                        acc <= acc + {{3{voice_sample[15]}}, voice_sample};
                    end else if (!timeout_hit) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                NEXT: begin
                    if (index != INDEX_LAST) begin
                        index <= index + 3'd1;
                    end
                end
                OUTPUT: begin
                    index <= '0;
                end
                default: begin
                    index <= '0;
                end
            endcase
        end
    end

`ifdef VOICE_SCHED_SATURATE_EN
    // In range exactly when the bits above the 16-bit sign bit all match it.
    always_comb begin
        if ((acc[18:15] == 4'b0000) || (acc[18:15] == 4'b1111)) begin
            result = acc[15:0];
        end else if (acc[18]) begin
            result = 16'h8000;
        end else begin
            result = 16'h7FFF;
        end
    end
`else
    assign result = 16'(acc);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (state == OUTPUT);
            if (state == OUTPUT) begin
                sample_out <= result;
            end
        end
    end

    // A new error event outranks a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= (overrun & ~clear_err) | (new_frame & busy);
            timeout_err <= (timeout_err & ~clear_err) | timeout_hit;
        end
    end

endmodule

// File: tb/tb_voice_frame_scheduler.sv
// Bench for voice_frame_scheduler: table of frames plus overrun and mid-frame reset sequences, scoreboarded on sample_valid.
`timescale 1ns/1ps
module tb_voice_frame_scheduler;

    localparam int NV = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          new_frame;
    logic [NV-1:0] voice_en;
    logic [2:0]    voice_sel;
    logic          voice_start;
    logic          voice_done;
    logic [15:0]   voice_sample;
    logic [15:0]   sample_out;
    logic          sample_valid;
    logic          busy;
    logic          overrun;
    logic          timeout_err;
    logic          clear_err;

    voice_frame_scheduler #(.NUM_VOICES(NV), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .new_frame   (new_frame),
        .voice_en    (voice_en),
        .voice_sel   (voice_sel),
        .voice_start (voice_start),
        .voice_done  (voice_done),
        .voice_sample(voice_sample),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]       en;
        logic [3:0][15:0] val;
        logic [3:0][7:0]  dly;   // 0 = voice never answers
        logic [15:0]      exp_wrap;
        logic [15:0]      exp_sat;
        logic             exp_to;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0][15:0] cur_val;
    logic [3:0][7:0]  cur_dly;
    int               countdown;
    logic [15:0]      pend_val;
    logic [7:0]       start_mask;
    int               start_cnt;
    int               valid_cnt;
    int               valid_cyc;
    logic [15:0]      exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] en,
                                input logic [15:0] v0, input logic [15:0] v1,
                                input logic [15:0] v2, input logic [15:0] v3,
                                input int d0, input int d1, input int d2, input int d3,
                                input logic [15:0] wrap, input logic [15:0] sat, input logic to);
        vec_t v;
        v.en       = en;
        v.val[0]   = v0; v.val[1] = v1; v.val[2] = v2; v.val[3] = v3;
        v.dly[0]   = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2); v.dly[3] = 8'(d3);
        v.exp_wrap = wrap;
        v.exp_sat  = sat;
        v.exp_to   = to;
        return v;
    endfunction

    function automatic logic [15:0] pick(input vec_t v);
`ifdef VOICE_SCHED_SATURATE_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    // Voice model: answers dly cycles after its voice_start pulse.
    initial begin : responder
        voice_done   = 1'b0;
        voice_sample = '0;
        countdown    = 0;
        pend_val     = '0;
        start_mask   = '0;
        start_cnt    = 0;
        forever begin
            @(negedge clk);
            voice_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    voice_done   = 1'b1;
                    voice_sample = pend_val;
                end
            end
            if (voice_start) begin
                start_mask[voice_sel] = 1'b1;
                start_cnt++;
                pend_val  = cur_val[voice_sel[1:0]];
                countdown = int'(cur_dly[voice_sel[1:0]]);
            end
        end
    end

    initial begin : monitor
        valid_cnt = 0;
        valid_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset_n && sample_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_valid: sample_out=%h with no frame outstanding", sample_out);
                end else begin
                    check("sample_out", {16'h0, sample_out}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic start_frame();
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 600 && valid_cnt == 0; i++) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int t0;
        int lat_exp;
        logic [15:0] exp;
        exp     = pick(v);
        lat_exp = 2;
        for (int i = 0; i < NV; i++)
            lat_exp += v.en[i] ? (2 + ((v.dly[i] == 0) ? TO : int'(v.dly[i]))) : 2;
        cur_val    = v.val;
        cur_dly    = v.dly;
        voice_en   = v.en;
        start_mask = '0;
        start_cnt  = 0;
        valid_cnt  = 0;
        exp_q.push_back(exp);
        @(negedge clk);
        new_frame = 1'b1;
        t0 = cyc;
        @(negedge clk);
        new_frame = 1'b0;
        wait_valid();
        repeat (4) @(negedge clk);
        check("valid_count", valid_cnt, 1);
        check("latency", valid_cyc - t0, lat_exp);
        check("start_mask", {24'h0, start_mask}, {28'h0, v.en});
        check("start_cnt", start_cnt, $countones(v.en));
        check("sample_hold", {16'h0, sample_out}, {16'h0, exp});
        check("timeout_err", {31'h0, timeout_err}, {31'h0, v.exp_to});
        check("busy_after", {31'h0, busy}, 32'h0);
        pulse_clear();
        check("timeout_cleared", {31'h0, timeout_err}, 32'h0);
    endtask

    initial begin : main
        vecs[0] = mk(4'hF, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 3, 3, 3, 3, 16'd4000, 16'd4000, 1'b0);
        vecs[1] = mk(4'hF, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 2, 2, 2, 2, 16'hC000, 16'h7FFF, 1'b0);
        vecs[2] = mk(4'h5, 16'd100, 16'h1234, 16'hFED4, 16'h5555, 4, 3, 1, 2, 16'hFF38, 16'hFF38, 1'b0);
        vecs[3] = mk(4'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1, 1, 1, 16'h0000, 16'h0000, 1'b0);
        vecs[4] = mk(4'hF, 16'd10, 16'd20, 16'd30, 16'd40, 2, 0, 5, 1, 16'd80, 16'd80, 1'b1);
        vecs[5] = mk(4'hF, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 1, 1, 1, 1, 16'h4000, 16'h8000, 1'b0);
        vecs[6] = mk(4'hE, 16'd777, 16'hFFFB, 16'd7, 16'hFFFF, 3, 6, 2, 1, 16'h0001, 16'h0001, 1'b0);

        reset_n   = 1'b0;
        new_frame = 1'b0;
        clear_err = 1'b0;
        voice_en  = '0;
        cur_val   = '0;
        cur_dly   = '0;
        repeat (3) @(negedge clk);
        check("rst_sample_out", {16'h0, sample_out}, 32'h0);
        check("rst_sample_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_voice_start", {31'h0, voice_start}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_voice_sel", {29'h0, voice_sel}, 32'h0);
        check("rst_flags", {30'h0, overrun, timeout_err}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Second new_frame mid-frame, coincident with clear_err: flag must still set.
        cur_val    = {16'd1, 16'd1, 16'd1, 16'd1};
        cur_dly    = {8'd3, 8'd3, 8'd3, 8'd3};
        voice_en   = 4'hF;
        valid_cnt  = 0;
        exp_q.push_back(16'd4);
        start_frame();
        repeat (3) @(negedge clk);
        new_frame = 1'b1;
        clear_err = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        clear_err = 1'b0;
        check("overrun_set", {31'h0, overrun}, 32'h1);
        check("busy_mid", {31'h0, busy}, 32'h1);
        wait_valid();
        repeat (4) @(negedge clk);
        check("overrun_one_valid", valid_cnt, 1);
        check("overrun_sticky", {31'h0, overrun}, 32'h1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("overrun_cleared", {31'h0, overrun}, 32'h0);

        // Reset while waiting on voice 1.
        cur_val    = {16'd2, 16'd2, 16'd2, 16'd2};
        cur_dly    = {8'd5, 8'd5, 8'd5, 8'd5};
        start_cnt  = 0;
        valid_cnt  = 0;
        exp_q.push_back(16'd8);
        start_frame();
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        for (int i = 0; i < 50 && start_cnt < 2; i++) @(negedge clk);
        @(negedge clk);
        check("pre_rst_overrun", {31'h0, overrun}, 32'h1);
        check("pre_rst_sel", {29'h0, voice_sel}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_sel", {29'h0, voice_sel}, 32'h0);
        check("mid_rst_sample_out", {16'h0, sample_out}, 32'h0);
        check("mid_rst_flags", {29'h0, overrun, timeout_err, voice_start}, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_valid_after_rst", valid_cnt, 0);
        check("idle_after_rst", {31'h0, busy}, 32'h0);
        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/voice_frame_scheduler.md
VOICE_FRAME_SCHEDULER -- requirements
Module: voice_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of voice generators sharing the sample path (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum clk cycles spent waiting on one voice.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_frame  input  1  one-cycle codec accept pulse; starts a frame.
REQ-006 SHALL have port voice_en  input  NUM_VOICES  per-voice enable (from DIP switches).
REQ-007 SHALL have port voice_sel  output  3  index of the voice currently owning the shared datapath.
REQ-008 SHALL have port voice_start  output  1  one-cycle request to the selected voice for its next sample.
REQ-009 SHALL have port voice_done  input  1  selected voice's sample is valid this cycle.
REQ-010 SHALL have port voice_sample  input  16  signed two's-complement voice sample.
REQ-011 SHALL have port sample_out  output  16  signed mixed frame sample to the codec.
REQ-012 SHALL have port sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port overrun  output  1  sticky: new_frame arrived while busy.
REQ-015 SHALL have port timeout_err  output  1  sticky: a voice failed to answer within TIMEOUT.
REQ-016 SHALL have port clear_err  input  1  synchronous clear of overrun and timeout_err.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, OUTPUT.
REQ-018 IDLE: new_frame=1 SHALL clear the accumulator, set voice index to 0, and go to ISSUE next cycle.
REQ-019 ISSUE: voice_en[index]=1 SHALL assert voice_start for exactly one cycle, load the wait counter with 0, and go to WAIT; voice_en[index]=0 SHALL go to NEXT with no voice_start.
REQ-020 WAIT: voice_done=1 SHALL add sign-extended voice_sample to a 19-bit signed accumulator and go to NEXT.
REQ-021 WAIT: counter reaching TIMEOUT-1 without voice_done SHALL add 0, set timeout_err, and go to NEXT.
REQ-022 NEXT: index==NUM_VOICES-1 SHALL go to OUTPUT; otherwise index SHALL increment and the FSM SHALL go to ISSUE.
REQ-023 OUTPUT: SHALL register the result into sample_out, pulse sample_valid for one cycle, and return to IDLE.
REQ-024 voice_sel SHALL equal the current index in every state; it SHALL hold 0 in IDLE.
REQ-025 new_frame in any state other than IDLE SHALL be ignored and SHALL set overrun.
REQ-026 voice_done outside WAIT SHALL be ignored.
REQ-027 voice_en SHALL be sampled per voice only in ISSUE; changes mid-frame affect only voices not yet issued.
REQ-028 All voices disabled SHALL produce sample_out=0 with sample_valid, 2*NUM_VOICES+2 cycles after new_frame.
REQ-029 clear_err together with a new error event in the same cycle SHALL leave the flag set.
REQ-030 sample_out SHALL hold its value between sample_valid pulses.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, index 0, accumulator 0, sample_out 0, sample_valid 0, voice_start 0, busy 0, overrun 0, timeout_err 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no sample_valid; after deassertion the FSM SHALL wait for the next new_frame.

Configuration
REQ-033 With macro VOICE_SCHED_SATURATE_EN defined, the OUTPUT result SHALL be the accumulator clamped to [-32768, 32767].
REQ-034 Without VOICE_SCHED_SATURATE_EN, the OUTPUT result SHALL be accumulator bits [15:0], which wrap on overflow.

Verification
REQ-035 voice_en=4'b1111, each voice answers done 3 cycles after start with 1000 -> sample_out=4000, one sample_valid, four voice_start pulses with voice_sel 0,1,2,3.
REQ-036 Four voices each return 16'h7000 -> sample_out=16'h7FFF with VOICE_SCHED_SATURATE_EN, and 16'hC000 without it.
REQ-037 voice_en=4'b0101, voices return 100 and -300 -> sample_out=-200, voice_start only while voice_sel=0 and voice_sel=2.
REQ-038 Voice 1 never asserts done, TIMEOUT=64 -> voice 1 contributes 0, timeout_err=1 until clear_err, and the frame still completes.
REQ-039 Second new_frame while busy -> overrun=1, exactly one sample_valid; clear_err -> overrun=0 next cycle.
REQ-040 reset_n pulsed low while in WAIT -> all outputs 0 immediately, no sample_valid, and the next new_frame runs a full frame normally.
